// File: rtl/efp_pkg.sv
// Shared EFP field definitions and the response FIFO entry type for the
// multiplier scheduler.
package efp_pkg;

  localparam int EFP_WIDTH  = 16;
  localparam int EFP_EXP_W  = 6;
  localparam int EFP_MBIT_W = 5;
  localparam int EFP_BIAS   = 31;
  // Sized for the largest supported requester count (8).
  localparam int EFP_ID_W   = 3;

  typedef struct packed {
    logic [EFP_ID_W-1:0]  id;
    logic [EFP_WIDTH-1:0] data;
  } efp_rsp_t;

  function automatic logic signed [EFP_EXP_W:0] efp_unbias(input logic [EFP_EXP_W-1:0] e_field);
    return $signed({1'b0, e_field}) - $signed((EFP_EXP_W+1)'(EFP_BIAS));
  endfunction

endpackage

// File: rtl/efp_rsp_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented whenever the FIFO
// is non-empty; a write into an empty FIFO appears on the following cycle.
module efp_rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/efp_mul_sched.sv
// Round-robin scheduler sharing one EFP multiplier between N_REQ requesters,
// returning tagged products in issue order through a credit-protected FIFO.
module efp_mul_sched
  import efp_pkg::*;
#(
  parameter int WIDTH      = EFP_WIDTH,
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*WIDTH-1:0]        req_a,
  input  logic [N_REQ*WIDTH-1:0]        req_b,
  input  logic [N_REQ*EFP_MBIT_W-1:0]   req_mbit_a,
  input  logic [N_REQ*EFP_MBIT_W-1:0]   req_mbit_b,
  output logic [WIDTH-1:0]              mul_a,
  output logic [WIDTH-1:0]              mul_b,
  output logic [EFP_MBIT_W-1:0]         mul_mbit_a,
  output logic [EFP_MBIT_W-1:0]         mul_mbit_b,
  input  logic [WIDTH-1:0]              mul_res,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic                          busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int CR_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CR_W-1:0] CREDIT_MAX = CR_W'(FIFO_DEPTH);

  logic [ID_W-1:0]       rr_ptr;
  logic [CR_W-1:0]       credits;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_vld;
  logic [ID_W:0]         scan_idx;
  logic                  accept;
  logic                  pop;
  logic [WIDTH-1:0]      sel_a;
  logic [WIDTH-1:0]      sel_b;
  logic [EFP_MBIT_W-1:0] sel_mbit_a;
  logic [EFP_MBIT_W-1:0] sel_mbit_b;

  // Scan from the farthest candidate back to the pointer so the nearest
  // valid requester at or after rr_ptr is the one left standing.
  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_REQ)) scan_idx = scan_idx - (ID_W+1)'(N_REQ);
      if (req_valid[scan_idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx[ID_W-1:0];
      end
    end
  end

  assign accept = rst_n && grant_vld && (credits != '0);
  assign pop    = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    sel_mbit_a = '0;
    sel_mbit_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a      = req_a[i*WIDTH +: WIDTH];
        sel_b      = req_b[i*WIDTH +: WIDTH];
        sel_mbit_a = req_mbit_a[i*EFP_MBIT_W +: EFP_MBIT_W];
        sel_mbit_b = req_mbit_b[i*EFP_MBIT_W +: EFP_MBIT_W];
      end
    end
  end

  // ---- issue stage: operands to the multiplier, pointer and credit update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      credits    <= CREDIT_MAX;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_mbit_a <= '0;
      mul_mbit_b <= '0;
    end else begin
      if (accept) begin
        rr_ptr     <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        mul_mbit_a <= sel_mbit_a;
        mul_mbit_b <= sel_mbit_b;
      end else begin
        // Idle operands drive the multiplier to a zero product.
        mul_a      <= '0;
        mul_b      <= '0;
        mul_mbit_a <= '0;
        mul_mbit_b <= '0;
      end
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) credits <= CREDIT_MAX);

  // ---- tag pipeline: issue valid and id track the multiplier latency
  logic            vld_p [MUL_LAT+1];
  logic [ID_W-1:0] id_p  [MUL_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= MUL_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int k = 1; k <= MUL_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= grant_id;
    for (int k = 1; k <= MUL_LAT; k++) id_p[k] <= id_p[k-1];
  end

  // ---- response stage: registered product plus tag into the FIFO
  efp_rsp_t wr_entry;
  efp_rsp_t head;
  logic     fifo_empty;
  logic     head_unused;

  assign wr_entry.id   = EFP_ID_W'(id_p[MUL_LAT]);
  assign wr_entry.data = EFP_WIDTH'(mul_res);

  efp_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (efp_rsp_t)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_p[MUL_LAT]),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign rsp_valid   = !fifo_empty;
  assign rsp_data    = head.data[WIDTH-1:0];
  assign rsp_id      = head.id[ID_W-1:0];
  assign head_unused = ^head;
  assign busy        = (credits != CREDIT_MAX);

endmodule

// File: tb/tb_efp_mul_sched.sv
// Scoreboard bench for efp_mul_sched with a behavioural stand-in multiplier.
`timescale 1ns/1ps
module tb_efp_mul_sched;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int D   = 4;
  localparam int LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [N*5-1:0]   req_mbit_a, req_mbit_b;
  logic [W-1:0]     mul_a, mul_b, mul_res;
  logic [4:0]       mul_mbit_a, mul_mbit_b;
  logic             rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [1:0]       rsp_id;
  logic             busy;

  efp_mul_sched #(.WIDTH(W), .N_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mbit_a(req_mbit_a), .req_mbit_b(req_mbit_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mbit_a(mul_mbit_a), .mul_mbit_b(mul_mbit_b),
    .mul_res(mul_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: zero in gives zero out, otherwise a deterministic
  // mix of every operand field so misrouted operands show up in the product.
  function automatic logic [W-1:0] mul_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [4:0] ma, input logic [4:0] mb);
    int e;
    logic [8:0] m;
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return '0;
    e = int'(a[14:9]) + int'(b[14:9]) - 31;
    if (e < 0) e = 0;
    if (e > 63) e = 63;
    m = a[8:0] + b[8:0] + 9'(ma) + 9'(mb);
    return {a[15] ^ b[15], 6'(e), m};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mul_res <= '0;
    else        mul_res <= mul_f(mul_a, mul_b, mul_mbit_a, mul_mbit_b);
  end

  typedef struct { logic [W-1:0] data; int id; int vis; } exp_t;
  typedef struct { logic [W-1:0] data; int id; } pop_t;

  exp_t       exp_q[$];
  pop_t       pop_log[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         in_reset;
  int         rr_ptr;
  int         acc_count;
  int         last_grant;
  bit         last_acc;
  logic [W-1:0] last_a, last_b;
  logic [4:0]   last_ma, last_mb;
  bit           pend[N];
  logic [W-1:0] pa[N], pb[N];
  logic [4:0]   pma[N], pmb[N];
  int           glog[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_a[i*W +: W]       = pa[i];
      req_b[i*W +: W]       = pb[i];
      req_mbit_a[i*5 +: 5]  = pma[i];
      req_mbit_b[i*5 +: 5]  = pmb[i];
    end
  endtask

  task automatic load_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] ma, input logic [4:0] mb);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pma[i] = ma; pmb[i] = mb;
  endtask

  // One clock period: drive at the falling edge, then check the arbitration
  // decision against the round-robin/credit rules and record any accept.
  task automatic run_cycle(input logic [N-1:0] new_mask, input logic rdy);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (!pend[i] && new_mask[i])
        load_req(i, 16'($urandom), 16'($urandom), 5'($urandom), 5'($urandom));
    drive_bus();
    rsp_ready = rdy;
    #1;
    check("mul_operands", {22'd0, mul_a, mul_b, mul_mbit_a, mul_mbit_b},
          last_acc ? {22'd0, last_a, last_b, last_ma, last_mb} : 64'd0);
    check("busy", busy, exp_q.size() != 0);
    g = -1;
    if (exp_q.size() < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(rr_ptr + k) % N]) g = (rr_ptr + k) % N;
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", req_ready, exp_rdy);
    last_acc   = (g >= 0);
    last_grant = g;
    if (g >= 0) begin
      exp_q.push_back('{data: mul_f(pa[g], pb[g], pma[g], pmb[g]), id: g, vis: cyc + LAT + 2});
      last_a = pa[g]; last_b = pb[g]; last_ma = pma[g]; last_mb = pmb[g];
      pend[g] = 1'b0;
      rr_ptr  = (g + 1) % N;
      acc_count++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_mul"}, {22'd0, mul_a, mul_b, mul_mbit_a, mul_mbit_b}, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: the head of the expected queue must be visible exactly once its
  // latency has elapsed, and must match until it is popped.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
        exp_v = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        check("rsp_valid", rsp_valid, exp_v);
        if (rsp_valid && exp_v) begin
          check("rsp_data", rsp_data, exp_q[0].data);
          check("rsp_id", rsp_id, exp_q[0].id);
          if (rsp_ready) begin
            pop_log.push_back('{data: rsp_data, id: int'(rsp_id)});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b1; in_reset = 1'b1; rsp_ready = 1'b0;
    rr_ptr = 0; acc_count = 0; last_acc = 1'b0; last_grant = -1;
    for (int i = 0; i < N; i++) load_req(i, '0, '0, '0, '0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_bus();
    #1 rst_n = 1'b0;
    @(negedge clk);
    req_valid = '1;
    #1 check_idle("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1; in_reset = 1'b0;

    // single requester
    load_req(0, 16'h3E04, 16'h3E04, 5'd3, 5'd3);
    run_cycle('0, 1'b1);
    check("single_grant", last_grant, 0);
    repeat (5) run_cycle('0, 1'b1);
    check("single_pop_count", pop_log.size(), 1);
    if (pop_log.size() > 0)
      check("single_pop", {pop_log[0].id, 16'd0, pop_log[0].data},
            {32'd0, 16'd0, mul_f(16'h3E04, 16'h3E04, 5'd3, 5'd3)});

    // all four streaming from pointer 0 (requester 3 first to move it there)
    load_req(3, 16'h1234, 16'h4321, 5'd1, 5'd2);
    repeat (5) run_cycle('0, 1'b1);
    pop_log.delete();
    for (int c = 0; c < 5; c++) begin
      run_cycle('1, 1'b1);
      glog[c] = last_grant;
    end
    repeat (10) run_cycle('0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("stream_grant", glog[c], c % N);
      if (pop_log.size() > c) check("stream_rsp_id", pop_log[c].id, c % N);
    end

    // backpressure: four credits, then one pop frees exactly one
    base = acc_count;
    repeat (8) run_cycle('1, 1'b0);
    check("bp_accepts", acc_count - base, 4);
    check("bp_busy", busy, 1);
    check("bp_ready_zero", req_ready, 0);
    pop_log.delete();
    base = acc_count;
    run_cycle('1, 1'b1);
    repeat (4) run_cycle('1, 1'b0);
    check("bp_one_pop", pop_log.size(), 1);
    if (pop_log.size() > 0) check("bp_pop_id", pop_log[0].id, 0);
    check("bp_one_accept", acc_count - base, 1);
    repeat (15) run_cycle('0, 1'b1);

    // zero operand passes straight through
    pop_log.delete();
    load_req(2, 16'h0000, 16'h3E00, 5'd4, 5'd2);
    repeat (6) run_cycle('0, 1'b1);
    check("zero_pop_count", pop_log.size(), 1);
    if (pop_log.size() > 0) check("zero_pop", {pop_log[0].id, 16'd0, pop_log[0].data}, {32'd2, 32'd0});

    // reset with three buffered and one in the pipe
    load_req(0, 16'h3C11, 16'h4022, 5'd5, 5'd6);
    load_req(1, 16'h3D33, 16'h4144, 5'd7, 5'd8);
    load_req(2, 16'hBE55, 16'h3F66, 5'd9, 5'd10);
    repeat (6) run_cycle('0, 1'b0);
    load_req(3, 16'h4277, 16'h3B88, 5'd11, 5'd12);
    run_cycle('0, 1'b0);
    run_cycle('0, 1'b0);
    check("pre_reset_valid", rsp_valid, 1);
    check("pre_reset_busy", busy, 1);
    in_reset = 1'b1;
    rst_n = 1'b0;
    req_valid = '1;
    #1 check_idle("midreset");
    exp_q.delete();
    rr_ptr = 0; last_acc = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    @(negedge clk);
    drive_bus();
    rst_n = 1'b1; in_reset = 1'b0;
    repeat (4) run_cycle('0, 1'b1);
    base = acc_count;
    run_cycle('1, 1'b0);
    check("post_reset_ptr", last_grant, 0);
    repeat (5) run_cycle('1, 1'b0);
    check("post_reset_credits", acc_count - base, 4);
    repeat (15) run_cycle('0, 1'b1);

    // random stress
    for (int c = 0; c < 10000; c++)
      run_cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    repeat (40) run_cycle('0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/efp_mul_sched.md
Name: efp_mul_sched

Overview:
- Shares one single-cycle EFP multiplier between N_REQ requesters. Each requester presents an operand pair with valid/ready.
- Round-robin arbitration; one operation issued per clock at most.
- Tracks requester ID through the multiplier's fixed latency and returns results in issue order through a credit-protected response FIFO.
- Sits between the EFP compute lanes and the shared multiplier instance.

Parameters:
- WIDTH, 16, EFP word width: sign [W-1], exponent [W-2:W-7] (6 bits, bias 31), mantissa [W-8:0].
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 1, multiplier latency in clock edges from operand change to registered result.
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >= MUL_LAT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B.
- req_mbit_a  in  N_REQ*5  mantissa bit count of A.
- req_mbit_b  in  N_REQ*5  mantissa bit count of B.
- mul_a  out  WIDTH  registered operand A to multiplier.
- mul_b  out  WIDTH  registered operand B to multiplier.
- mul_mbit_a  out  5  registered m_bit of A.
- mul_mbit_b  out  5  registered m_bit of B.
- mul_res  in  WIDTH  multiplier result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  product.
- rsp_id  out  $clog2(N_REQ)  originating requester.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset (async, rst_n=0): req_ready=0, mul_* = 0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. RR pointer=0, credits=FIFO_DEPTH, tag pipeline and FIFO cleared. Reset mid-operation discards all in-flight and buffered results.
- Credit counter:
  - Starts at FIFO_DEPTH.
  - Decrements on accept; increments on response pop (rsp_valid & rsp_ready).
  - Simultaneous accept and pop leaves it unchanged.
  - Never exceeds FIFO_DEPTH and never goes below 0.
- Arbitration:
  - Combinational. If credits>0, grant the first valid requester at or after the RR pointer, wrapping.
  - req_ready[grant]=1 and all other req_ready=0. req_ready may depend on req_valid.
  - If credits==0, all req_ready=0.
- Accept = req_valid[i] & req_ready[i].
- On accept at edge E0:
  - RR pointer <= (i+1) mod N_REQ.
  - mul_a/b/mbit registered from requester i.
  - Issue-valid and id enter a shift pipeline of length MUL_LAT+1.
- Without accept: mul_a=mul_b=0 so the multiplier outputs 0. Pointer holds.
- At edge E0+MUL_LAT+1: {mul_res, id} written to the FIFO. Space is guaranteed by the credit rule; overflow is a design error and an assertion must check for it.
- FIFO is show-ahead: rsp_valid=!empty; rsp_data/rsp_id come from the head entry.
  - Default-parameter latency: accept at E0 gives rsp_valid high after E2.
  - Back-to-back accepts give back-to-back responses.
  - Responses are in issue order.
- rsp_valid must stay stable and rsp_data/rsp_id must not change while rsp_valid & !rsp_ready.
- Simultaneous FIFO write and pop: both happen and occupancy is unchanged. Write into an empty FIFO becomes visible the next cycle (no bypass).
- busy = (credits != FIFO_DEPTH).
- Operands are passed through unmodified, including zero operands; zero handling belongs to the multiplier.
- Requesters must hold operands stable while valid & !ready; violation is undefined.

Decomposition:
- efp_pkg holds EFP_EXP_W=6, EFP_MBIT_W=5, EFP_BIAS=31, default WIDTH, and a packed struct efp_rsp_t {id, data}.
- One sub-module: efp_rsp_fifo, a synchronous show-ahead FIFO parameterised by depth and data type, with async active-low reset.
- Arbiter, credit counter and tag pipeline stay in efp_mul_sched.

Test Plan:
- Single requester:
  - Stimulus: req 0 with a=0x3E04, b=0x3E04, mbit 3/3, connected to the real multiplier.
  - Response: req_ready[0]=1 the same cycle; rsp_valid 2 edges later with rsp_data=0x4000, rsp_id=0.
- All four requesters valid continuously with pointer at 0, rsp_ready=1:
  - Grants in order 0,1,2,3,0 on consecutive cycles.
  - Response ids follow 0,1,2,3 in order, one per cycle.
- rsp_ready=0 with requesters streaming:
  - Exactly 4 accepts occur, then req_ready stays 0 and busy=1.
  - Raising rsp_ready for one cycle pops id 0 and allows exactly one new accept.
  - No result is lost or duplicated (scoreboard).
- Zero operand: a=0x0000, b=0x3E00 -> rsp_data=0x0000 with the correct id.
- Reset mid-flight: assert rst_n=0 with 3 results buffered and 1 in the pipe.
  - All outputs go to 0 immediately.
  - After release, credits=4, pointer=0, and there are no stale responses.
- Random stress: random valid/ready per cycle, 10k cycles, compared against a reference model.
  - Order and id match.
  - FIFO never overflows.
  - Output is stable under backpressure.
